// File: rtl/log_drain_if.sv
// Bus bundle between log_drain and its neighbours:
// the log RAM read port and the framed byte stream.
interface log_drain_if #(
   parameter int DATA_WIDTH = 37,
   parameter int ADDR_WIDTH = 16
);
   logic                  re;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (
      output re,
      output rd_addr,
      output tx_data,
      output tx_valid,
      input  rd_data,
      input  tx_ready
   );

   modport slave (
      input  re,
      input  rd_addr,
      input  tx_data,
      input  tx_valid,
      output rd_data,
      output tx_ready
   );
endinterface

// File: rtl/log_drain.sv
// Drains the violation logger RAM into a framed byte stream:
// A5, count hi/lo, 5 bytes per record, 5A, then optional RAM clear.
module log_drain #(
   parameter int DATA_WIDTH      = 37,
   parameter int ADDR_WIDTH      = 16,
   parameter int DEPTH           = 256,
   parameter int CLR_AFTER_DRAIN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] entry_count,
   log_drain_if.master           bus,
   output logic                  busy,
   output logic                  done,
   output logic                  clr_ram
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_CNT_HI,
      S_CNT_LO,
      S_RD_REQ,
      S_RD_WAIT,
      S_SEND,
      S_TRL,
      S_CLR,
      S_DONE
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [2:0]            bi_q, bi_d;
   logic [DATA_WIDTH-1:0] rec_q, rec_d;

   logic [ADDR_WIDTH-1:0] snap;
   logic [ADDR_WIDTH-1:0] idx_nxt;
   logic [7:0]            rec_byte;
   logic                  accept;

   assign snap    = (entry_count > DEPTH_W) ? DEPTH_W : entry_count;
   assign idx_nxt = idx_q + ADDR_WIDTH'(1);
   assign accept  = bus.tx_valid && bus.tx_ready;

   always_comb begin
      rec_byte = rec_q[7:0];
      unique case (bi_q)
         3'd0:    rec_byte = {3'b000, rec_q[36:32]};
         3'd1:    rec_byte = rec_q[31:24];
         3'd2:    rec_byte = rec_q[23:16];
         3'd3:    rec_byte = rec_q[15:8];
         default: rec_byte = rec_q[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         idx_q   <= '0;
         bi_q    <= '0;
         rec_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         bi_q    <= bi_d;
         rec_q   <= rec_d;
      end
   end

   // Outputs decode from registered state only, so tx_valid
   // never depends combinationally on tx_ready.
   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.re       = 1'b0;
      bus.rd_addr  = '0;
      busy         = (state_q != S_IDLE);
      done         = 1'b0;
      clr_ram      = 1'b0;
      unique case (state_q)
         S_HDR: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hA5;
         end
         S_CNT_HI: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = n_q[15:8];
         end
         S_CNT_LO: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = n_q[7:0];
         end
         S_RD_REQ: begin
            bus.re      = 1'b1;
            bus.rd_addr = idx_q;
         end
         S_SEND: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = rec_byte;
         end
         S_TRL: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'h5A;
         end
         S_CLR:   clr_ram = 1'b1;
         S_DONE:  done    = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      bi_d    = bi_q;
      rec_d   = rec_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               n_d     = snap;
               idx_d   = '0;
               bi_d    = '0;
            end
         end
         S_HDR: begin
            if (accept) state_d = S_CNT_HI;
         end
         S_CNT_HI: begin
            if (accept) state_d = S_CNT_LO;
         end
         S_CNT_LO: begin
            if (accept) state_d = (n_q != '0) ? S_RD_REQ : S_TRL;
         end
         S_RD_REQ: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            rec_d   = bus.rd_data;
            bi_d    = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (accept) begin
               if (bi_q != 3'd4) begin
                  bi_d = bi_q + 3'd1;
               end else begin
                  idx_d   = idx_nxt;
                  state_d = (idx_nxt < n_q) ? S_RD_REQ : S_TRL;
               end
            end
         end
         S_TRL: begin
            if (accept) state_d = (CLR_AFTER_DRAIN != 0) ? S_CLR : S_DONE;
         end
         S_CLR:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule
